// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receive path.
package uart_rx_pkg;

   localparam int unsigned UART_DIV_RATE   = 15;
   localparam int unsigned UART_DIV_CNT_W  = 4;
   localparam int unsigned UART_RX_STATE_W = 2;
   localparam int unsigned BYTE_W          = 8;
   localparam int unsigned BIT_CNT_W       = 3;

   localparam logic UART_START_BIT = 1'b0;
   localparam logic UART_STOP_BIT  = 1'b1;

   typedef enum logic [UART_RX_STATE_W-1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   typedef logic [BYTE_W-1:0] byte_data_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, holds the byte until acknowledged.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned DIV_RATE  = UART_DIV_RATE,
   parameter int unsigned DIV_CNT_W = UART_DIV_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              rx_busy,
   output logic              frame_err,
   output logic              overrun
);

   rx_state_e              state, next_state;
   logic                   rxs;
   logic [DIV_CNT_W-1:0]   div_cnt;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   byte_data_t             sh_reg;
   logic                   brk;

   logic div_zero, bit_last;
   logic div_load_half, div_load_full, div_dec;
   logic bit_clr, shift_en, stop_sample;
   logic deliver, stop_bad;

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rxs)
   );

   assign div_zero = (div_cnt == '0);
   assign bit_last = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
   assign rx_busy  = (state != RX_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RX_IDLE;
      else        state <= next_state;
   end

   // After a bad stop bit the line must be seen high before a new start is accepted.
   always_comb begin
      next_state = state;
      case (state)
         RX_IDLE:  if (rxs == UART_START_BIT && !brk) next_state = RX_START;
         RX_START: if (div_zero) next_state = (rxs == UART_START_BIT) ? RX_DATA : RX_IDLE;
         RX_DATA:  if (div_zero && bit_last) next_state = RX_STOP;
         RX_STOP:  if (div_zero) next_state = RX_IDLE;
         default:  next_state = RX_IDLE;
      endcase
   end

   always_comb begin
      div_load_half = 1'b0;
      div_load_full = 1'b0;
      div_dec       = 1'b0;
      bit_clr       = 1'b0;
      shift_en      = 1'b0;
      stop_sample   = 1'b0;
      case (state)
         RX_IDLE:  div_load_half = (rxs == UART_START_BIT) && !brk;
         RX_START: begin
            if (!div_zero) begin
               div_dec = 1'b1;
            end else if (rxs == UART_START_BIT) begin
               div_load_full = 1'b1;
               bit_clr       = 1'b1;
            end
         end
         RX_DATA: begin
            if (div_zero) begin
               shift_en      = 1'b1;
               div_load_full = 1'b1;
            end else begin
               div_dec = 1'b1;
            end
         end
         RX_STOP: begin
            if (div_zero) stop_sample = 1'b1;
            else          div_dec     = 1'b1;
         end
         default: ;
      endcase
   end

   assign deliver  = stop_sample && (rxs == UART_STOP_BIT);
   assign stop_bad = stop_sample && (rxs != UART_STOP_BIT);

   // Divider, bit counter and shift register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         sh_reg  <= '0;
      end else begin
         if (div_load_half)      div_cnt <= DIV_CNT_W'(DIV_RATE / 2);
         else if (div_load_full) div_cnt <= DIV_CNT_W'(DIV_RATE);
         else if (div_dec)       div_cnt <= div_cnt - DIV_CNT_W'(1);
         if (bit_clr)       bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
         if (shift_en) sh_reg <= {rxs, sh_reg[BYTE_W-1:1]};
      end
   end

   // Hand-off to the bus side; a same-cycle ack lets the new byte replace the old one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         brk       <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= deliver && rx_valid && !rx_ack;
         if (stop_bad)                     brk <= 1'b1;
         else if (rxs == UART_STOP_BIT)    brk <= 1'b0;
         if (deliver) begin
            if (!rx_valid || rx_ack) begin
               rx_data  <= sh_reg;
               rx_valid <= 1'b1;
            end
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; the bench plays the transmitter.
module tb_uart_rx;

   localparam int unsigned BIT_CLK = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;

   uart_rx #(.DIV_RATE(15), .DIV_CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ack    (rx_ack),
      .rx_busy   (rx_busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
      rx = 1'b1;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!rx_valid && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic pulse_ack();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      @(negedge clk);
   endtask

   int         cyc;
   int         fe0, ov0;
   logic [7:0] got [3];

   initial begin
      reset  = 1'b0;
      rx     = 1'b1;
      rx_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(rx_valid), 32'd0);
      check("rst_data",  32'(rx_data),  32'h00);
      check("rst_busy",  32'(rx_busy),  32'd0);
      check("rst_flags", 32'({frame_err, overrun}), 32'd0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // Single frame with latency measured from the start edge.
      fe0 = fe_cnt;
      fork
         send_frame(8'hA5, 1'b1);
         wait_valid(cyc);
      join
      check("a5_valid",   32'(rx_valid), 32'd1);
      check("a5_data",    32'(rx_data),  32'hA5);
      check("a5_latency", 32'(cyc),      32'd155);
      check("a5_ferr",    32'(fe_cnt - fe0), 32'd0);
      pulse_ack();
      check("ack_clears", 32'(rx_valid), 32'd0);

      // False start: line low for only 5 clocks.
      fe0 = fe_cnt; ov0 = ov_cnt;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      check("fs_busy",  32'(rx_busy), 32'd1);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("fs_idle",  32'(rx_busy),  32'd0);
      check("fs_valid", 32'(rx_valid), 32'd0);
      check("fs_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

      // Bad stop bit.
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0);
      repeat (20) @(negedge clk);
      check("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
      check("fe_valid", 32'(rx_valid),    32'd0);
      check("fe_idle",  32'(rx_busy),     32'd0);

      // Break: long low line reports once, then waits for the line to go high.
      fe0 = fe_cnt;
      rx = 1'b0;
      repeat (400) @(negedge clk);
      check("brk_idle", 32'(rx_busy), 32'd0);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("brk_ferr",  32'(fe_cnt - fe0), 32'd1);
      check("brk_valid", 32'(rx_valid),    32'd0);

      // Overrun without ack.
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b1);
      check("ov_first", 32'(rx_data), 32'h11);
      send_frame(8'h22, 1'b1);
      repeat (2) @(negedge clk);
      check("ov_pulse", 32'(ov_cnt - ov0), 32'd1);
      check("ov_data",  32'(rx_data),      32'h11);
      check("ov_valid", 32'(rx_valid),     32'd1);
      pulse_ack();

      // Ack on the stop-sample clock lets the new byte through.
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b1);
      check("sa_first", 32'(rx_data), 32'h11);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (154) @(negedge clk);
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      check("sa_data",  32'(rx_data),      32'h22);
      check("sa_valid", 32'(rx_valid),     32'd1);
      check("sa_novr",  32'(ov_cnt - ov0), 32'd0);
      pulse_ack();

      // Back-to-back frames, consumer acks each one.
      fe0 = fe_cnt; ov0 = ov_cnt;
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
            send_frame(8'h55, 1'b1);
         end
         for (int i = 0; i < 3; i++) begin
            wait_valid(cyc);
            got[i] = rx_valid ? rx_data : 8'hEE;
            pulse_ack();
         end
      join
      check("b2b_0", 32'(got[0]), 32'h00);
      check("b2b_1", 32'(got[1]), 32'hFF);
      check("b2b_2", 32'(got[2]), 32'h55);
      check("b2b_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

      // Leave a byte pending, then reset in the middle of a frame.
      send_frame(8'h5A, 1'b1);
      check("pre_rst", 32'(rx_valid), 32'd1);
      fork
         send_frame(8'h96, 1'b1);
         begin
            repeat (60) @(negedge clk);
            check("mid_busy", 32'(rx_busy), 32'd1);
            reset = 1'b0;
            @(negedge clk);
            check("mr_valid", 32'(rx_valid), 32'd0);
            check("mr_data",  32'(rx_data),  32'h00);
            check("mr_busy",  32'(rx_busy),  32'd0);
            check("mr_flags", 32'({frame_err, overrun}), 32'd0);
         end
      join
      reset = 1'b1;
      repeat (10) @(negedge clk);
      send_frame(8'h69, 1'b1);
      check("post_rst_valid", 32'(rx_valid), 32'd1);
      check("post_rst_data",  32'(rx_data),  32'h69);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
